updown_mod_counter: RTL

//  Parametrised synchronous up/down counter with parallel load and programmable modulus.

---
 rtl/updown_mod_counter.sv | 110 +++++++++++
 1 files changed

// File: rtl/updown_mod_counter.sv
// Up/down counter with parallel load, runtime modulus (0..Limit), wrap or saturate
// at the bounds, and registered single-cycle carry/borrow pulses.
module updown_mod_counter #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         En,
  input  logic         Load,
  input  logic         Up,
  input  logic         Sat,
  input  logic [N-1:0] In,
  input  logic [N-1:0] Limit,
  output logic [N-1:0] Out,
  output logic         Cout,
  output logic         Bout,
  output logic         Zero
);

  localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
  localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] cnt_r;
  logic         cout_r;
  logic         bout_r;
  logic [N-1:0] cnt_next_s;
  logic         cout_next_s;
  logic         bout_next_s;

  // Next-state selection: Load beats En; bounds are always judged against the live Limit
  always_comb begin
    cnt_next_s  = cnt_r;
    cout_next_s = 1'b0;
    bout_next_s = 1'b0;
    if (Load) begin
      cnt_next_s = (In > Limit) ? Limit : In;
    end else if (En) begin
      if (Up) begin
        if (cnt_r < Limit) begin
          cnt_next_s = cnt_r + CNT_ONE;
        end else begin
          cnt_next_s  = Sat ? Limit : CNT_ZERO;
          cout_next_s = 1'b1;
        end
      end else begin
        if (cnt_r > Limit) begin
          // Out of range after Limit was lowered: pull back in without a borrow
          cnt_next_s = Limit;
        end else if (cnt_r != CNT_ZERO) begin
          cnt_next_s = cnt_r - CNT_ONE;
        end else begin
          cnt_next_s  = Sat ? CNT_ZERO : Limit;
          bout_next_s = 1'b1;
        end
      end
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // State and pulse registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= CNT_ZERO;
      cout_r <= 1'b0;
      bout_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      cout_r <= cout_next_s;
      bout_r <= bout_next_s;
    end
  end

  assign Out  = cnt_r;
  assign Cout = cout_r;
  assign Bout = bout_r;
  assign Zero = (cnt_r == CNT_ZERO);

  updown_mod_counter_chk #(.N(N)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .Out   (cnt_r),
    .Cout  (cout_r),
    .Bout  (bout_r),
    .Zero  (Zero)
  );

endmodule

// Invariant checker: pulses are mutually exclusive and Zero tracks Out.
module updown_mod_counter_chk #(
  parameter int N = 10
) (
  input logic         clk,
  input logic         rst,
  input logic [N-1:0] Out,
  input logic         Cout,
  input logic         Bout,
  input logic         Zero
);

  // Sample invariants once per active edge outside reset
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(Cout && Bout)) else $error("carry and borrow high together");
      assert (Zero == (Out == {N{1'b0}})) else $error("zero flag disagrees with count");
    end
  end

endmodule
